// File: rtl/radixf_seq.sv
// Multi-word radix-16 adder controller: one shared radixf hex adder is stepped over
// WORDS words, least-significant first, with the carry chained through a register.

module radixf #(
    parameter int M = 4
) (
    input  logic [4*M-1:0] x,
    input  logic [4*M-1:0] y,
    input  logic           cin,
    output logic [4*M-1:0] sum,
    output logic           cout
);
    logic [4:0] digit_s;
    logic       chain_s;

    // Ripple hex digits: each digit sum is 0..31, bit 4 is the carry into the next digit.
    always_comb begin
        sum     = '0;
        digit_s = 5'd0;
        chain_s = cin;
        for (int i = 0; i < M; i++) begin
            digit_s          = {1'b0, x[4*i +: 4]} + {1'b0, y[4*i +: 4]} + {4'd0, chain_s};
            sum[4*i +: 4]    = digit_s[3:0];
            chain_s          = digit_s[4];
        end
        cout = chain_s;
    end
endmodule

module radixf_seq #(
    parameter int M     = 4,
    parameter int WORDS = 4,
    parameter int IW    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   acc,
    input  logic [4*M*WORDS-1:0]   a,
    input  logic [4*M*WORDS-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*M*WORDS-1:0]   result,
    output logic                   cout
);
    localparam int W = 4 * M;
    localparam int N = W * WORDS;

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          state_r, state_nxt_s;
    logic [N-1:0]    a_r, a_nxt_s;
    logic [N-1:0]    b_r, b_nxt_s;
    logic [N-1:0]    result_r, result_nxt_s;
    logic            carry_r, carry_nxt_s;
    logic [IW-1:0]   index_r, index_nxt_s;
    logic            cout_r, cout_nxt_s;
    logic            done_r, done_nxt_s;
    logic            busy_r, busy_nxt_s;

    logic [W-1:0]    x_s, y_s, sum_s;
    logic            rcout_s;
    logic            last_s;

    // Select the operand words addressed by the index register.
    always_comb begin
        x_s = '0;
        y_s = '0;
        for (int w = 0; w < WORDS; w++) begin
            x_s = (index_r == IW'(w)) ? a_r[w*W +: W] : x_s;
            y_s = (index_r == IW'(w)) ? b_r[w*W +: W] : y_s;
        end
    end

    assign last_s = (index_r == IW'(WORDS - 1));

    radixf #(.M(M)) u_adder (
        .x    (x_s),
        .y    (y_s),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (rcout_s)
    );

    // Next-state and next-register values for the sequencer.
    always_comb begin
        state_nxt_s  = state_r;
        a_nxt_s      = a_r;
        b_nxt_s      = b_r;
        result_nxt_s = result_r;
        carry_nxt_s  = carry_r;
        index_nxt_s  = index_r;
        cout_nxt_s   = cout_r;
        done_nxt_s   = 1'b0;
        busy_nxt_s   = busy_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                    busy_nxt_s  = 1'b1;
                    a_nxt_s     = a;
                    // Accumulate snapshots the held result before any word is overwritten.
                    b_nxt_s     = acc ? result_r : b;
                    carry_nxt_s = cin;
                    index_nxt_s = '0;
                end else begin
                    state_nxt_s = IDLE;
                    busy_nxt_s  = 1'b0;
                end
            end
            RUN: begin
                for (int w = 0; w < WORDS; w++) begin
                    if (index_r == IW'(w)) begin
                        result_nxt_s[w*W +: W] = sum_s;
                    end else begin
                        result_nxt_s[w*W +: W] = result_r[w*W +: W];
                    end
                end
                carry_nxt_s = rcout_s;
                index_nxt_s = index_r + IW'(1);
                if (last_s) begin
                    cout_nxt_s  = rcout_s;
                    state_nxt_s = IDLE;
                    done_nxt_s  = 1'b1;
                    busy_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = RUN;
                    busy_nxt_s  = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            carry_r  <= 1'b0;
            index_r  <= '0;
            cout_r   <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            a_r      <= a_nxt_s;
            b_r      <= b_nxt_s;
            result_r <= result_nxt_s;
            carry_r  <= carry_nxt_s;
            index_r  <= index_nxt_s;
            cout_r   <= cout_nxt_s;
            done_r   <= done_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign cout   = cout_r;
endmodule

// File: tb/tb_radixf_seq.sv
// Directed bench for radixf_seq: each task drives one scenario and checks inline.

module tb_radixf_seq;
    logic        clk;
    logic        rst;
    logic        start;
    logic        acc;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        cout;

    int n_cmp;
    int n_bad;

    radixf_seq #(.M(4), .WORDS(4), .IW(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .acc    (acc),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation at the current negedge and wait for done; counts edges
    // from the accepting edge and cycles with busy high.
    task automatic run_op(input logic acc_i, input logic [63:0] a_i, input logic [63:0] b_i,
                          input logic cin_i, output int edges, output int busy_cyc);
        edges    = 0;
        busy_cyc = 0;
        start = 1'b1; acc = acc_i; a = a_i; b = b_i; cin = cin_i;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cyc++;
            if (done) break;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL run_op_timeout: done=%b required 1", done);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; acc = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        n_cmp++;
        if ({busy, done, cout} !== 3'b000 || result !== 64'h0) begin
            n_bad++;
            $display("FAIL reset: busy=%b done=%b cout=%b result=%h required all 0", busy, done, cout, result);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int e, bc;
        run_op(1'b0, 64'h121a, 64'h211b, 1'b0, e, bc);
        n_cmp++;
        if (e !== 5) begin n_bad++; $display("FAIL basic_latency: edges=%0d required 5", e); end
        n_cmp++;
        if (bc !== 4) begin n_bad++; $display("FAIL basic_busy: busy cycles=%0d required 4", bc); end
        n_cmp++;
        if (result !== 64'h3335 || cout !== 1'b0) begin
            n_bad++; $display("FAIL basic_result: result=%h cout=%b required 3335 0", result, cout);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: done=%b required 0", done); end
    endtask

    task automatic test_accumulate;
        int e, bc;
        run_op(1'b1, 64'h3335, 64'hdead_beef, 1'b0, e, bc);
        n_cmp++;
        if (result !== 64'h666a || cout !== 1'b0) begin
            n_bad++; $display("FAIL accumulate: result=%h cout=%b required 666a 0", result, cout);
        end
        @(negedge clk);
    endtask

    task automatic test_carry;
        int e, bc;
        run_op(1'b0, 64'hffff, 64'h1, 1'b0, e, bc);
        n_cmp++;
        if (result !== 64'h0000_0000_0001_0000 || cout !== 1'b0) begin
            n_bad++; $display("FAIL carry_word: result=%h cout=%b required 10000 0", result, cout);
        end
        @(negedge clk);
        run_op(1'b0, 64'hffff_ffff_ffff_ffff, 64'h0, 1'b1, e, bc);
        n_cmp++;
        if (result !== 64'h0 || cout !== 1'b1) begin
            n_bad++; $display("FAIL carry_wrap: result=%h cout=%b required 0 1", result, cout);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int k;
        start = 1'b1; acc = 1'b0; a = 64'h121a; b = 64'h211b; cin = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        // Intruding start while busy must be ignored.
        start = 1'b1; a = 64'hffff; b = 64'hffff; cin = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(posedge clk); @(negedge clk);
            k++;
        end
        n_cmp++;
        if (result !== 64'h3335 || cout !== 1'b0 || done !== 1'b1) begin
            n_bad++; $display("FAIL busy_ignore: result=%h cout=%b done=%b required 3335 0 1", result, cout, done);
        end
        start = 1'b1; a = 64'h1; b = 64'h1; cin = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL b2b_accept: busy=%b done=%b required 1 0", busy, done);
        end
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(posedge clk); @(negedge clk);
            k++;
        end
        n_cmp++;
        if (result !== 64'h2 || done !== 1'b1) begin
            n_bad++; $display("FAIL b2b_result: result=%h done=%b required 2 1", result, done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int e, bc;
        start = 1'b1; acc = 1'b0; a = 64'h121a; b = 64'h211b; cin = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, cout} !== 3'b000 || result !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_mid: busy=%b done=%b cout=%b result=%h required all 0", busy, done, cout, result);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(1'b0, 64'h1, 64'h2, 1'b0, e, bc);
        n_cmp++;
        if (result !== 64'h3 || cout !== 1'b0) begin
            n_bad++; $display("FAIL reset_recover: result=%h cout=%b required 3 0", result, cout);
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_accumulate();
        test_carry();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/radixf_seq.md
Name: radixf_seq

Overview:
- Multi-word radix-16 addition controller. Sequences one shared radixf adder instance (4*M-bit hex adder with x, y, cin, sum, cout) over WORDS words, least-significant word first, chaining cout into the next word's cin.
- Adds wide operands without replicating the adder; optional accumulate mode adds a new operand to the held result.
- Sits between a requesting datapath (start/done handshake) and the radixf datapath.

Parameters:
- M, 4, hex digits per word; word width W = 4*M, must equal the radixf operand width.
- WORDS, 4, number of words per operand; total width N = W*WORDS.
- IW, 2, index counter width, >= clog2(WORDS).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- acc  in  1  mode at start: 0 computes a+b+cin, 1 computes result+a+cin.
- a  in  N  operand A; captured at accepted start.
- b  in  N  operand B; captured at accepted start, ignored when acc=1.
- cin  in  1  carry into word 0; captured at accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when a result is complete.
- result  out  N  sum register; holds its value until the next accepted start.
- cout  out  1  carry out of the top word; registered with result.

Behaviour:
- Reset (asynchronous, any time, including mid-operation) forces:
  - state IDLE, busy=0, done=0, result=0, cout=0.
  - index=0, carry register=0, operand registers=0.
- States:
  - IDLE: busy=0. When start=1 at a clock edge, go to RUN at that edge (E0). At E0:
    - A register <= a.
    - B register <= acc ? result : b. The current result is snapshotted here, before any overwrite.
    - carry <= cin; index <= 0.
  - RUN: busy=1. On each edge E1..E_WORDS:
    - Drive radixf x=A word[index], y=B word[index], cin=carry.
    - result word[index] <= sum; carry <= radixf cout; index <= index+1.
    - On the edge where index==WORDS-1: cout <= radixf cout, state <= IDLE, done <= 1.
- Radixf drive values are combinational from the registers. Words not yet written keep their prior result value during RUN; result is valid only when done=1 or afterwards.
- done is high for exactly the one cycle after E_WORDS; otherwise 0.
- Latency: start accepted at E0, done high after E_WORDS. That is WORDS+1 edges; a new start can be accepted every WORDS+1 cycles.
- Back-to-back: start=1 during the done cycle is accepted, since the state is IDLE. done still deasserts at the next edge.
- start while busy=1 is ignored and not queued. Changes to a, b, cin or acc during RUN have no effect.
- Arithmetic: result = (A + B + cin) mod 2^N; cout = bit N of the full sum. Wrap-around is silent, with cout=1 reporting the overflow.
- WORDS=1 is legal: done follows E1 directly.

Test Plan:
- Basic (acc=0): a=64'h121a, b=64'h211b, cin=0 → done exactly 5 cycles after the start edge; result=64'h3335, cout=0, busy high for 4 cycles.
- Inter-word carry: a=64'hffff, b=64'h1, cin=0 → result=64'h0000_0000_0001_0000, cout=0. Then a=64'hffff_ffff_ffff_ffff, b=0, cin=1 → result=0, cout=1.
- Accumulate: after the basic case, start with acc=1, a=64'h3335, b=64'hdead_beef (ignored), cin=0 → result=64'h666a, cout=0.
- Busy protection and back-to-back: pulse start with different a, b during RUN → result unaffected (still 64'h3335). Assert start in the done cycle → second operation accepted; busy high on the next cycle.
- Reset mid-operation: assert rst two cycles into RUN → busy, done, result, cout all 0 immediately (asynchronous). After release, a new start with a=1, b=2 → result=3.
